// File: rtl/karatsuba_combine16_if.sv
// Operand/result handshake bundle for karatsuba_combine16.
// master: partial-product producer and result consumer side.
// slave:  the recombination stage itself.
interface karatsuba_combine16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z0;
  logic [17:0] z1;
  logic [15:0] z2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;
  logic        err;

  modport master (
    output in_valid, z0, z1, z2, out_ready,
    input  in_ready, out_valid, prod, err
  );

  modport slave (
    input  in_valid, z0, z1, z2, out_ready,
    output in_ready, out_valid, prod, err
  );
endinterface

// File: rtl/karatsuba_combine16.sv
// Sequential recombination stage of the 16x16 Karatsuba multiplier.
// Builds P = (z2<<16) + ((z1-z0-z2)<<8) + z0 by time-multiplexing one
// 16-bit square-root carry-select adder over SUB0/SUB2/ADDL/ADDH.
// Optional feature macro: KCOMB_CHECK_EN (borrow/overflow flag on err).

// 16-bit carry-select adder with growing block sizes 2,2,3,4,5.
module scb_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  localparam int NB = 5;
  localparam int LO [NB] = '{0, 2, 4, 7, 11};
  localparam int WD [NB] = '{2, 2, 3, 4, 5};

  logic [NB:0] c;
  assign c[0] = cin;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int L = LO[i];
    localparam int N = WD[i];
    logic [N:0] s0;
    logic [N:0] s1;
    // Both carry-in hypotheses are summed in parallel; the incoming carry selects.
    assign s0 = {1'b0, a[L +: N]} + {1'b0, b[L +: N]};
    assign s1 = {1'b0, a[L +: N]} + {1'b0, b[L +: N]} + (N + 1)'(1);
    assign sum[L +: N] = c[i] ? s1[N-1:0] : s0[N-1:0];
    assign c[i+1]      = c[i] ? s1[N]     : s0[N];
  end

  assign cout = c[NB];
endmodule

module karatsuba_combine16 #(
  parameter int HALF = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  karatsuba_combine16_if.slave bus
);
  if (HALF != 8) begin : g_half_check
    $error("karatsuba_combine16: only HALF=8 is supported");
  end

  typedef enum logic [2:0] {IDLE, SUB0, SUB2, ADDL, ADDH, DONE} state_t;

  state_t      state;
  logic [15:0] z0_q;
  logic [17:0] z1_q;
  logic [15:0] z2_q;
  logic [17:0] d_q;
  logic [17:0] mid_q;
  logic        c_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] prod_q;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;
  logic [1:0]  hi_a;

`ifdef KCOMB_CHECK_EN
  logic [2:0]  hi_sum;
  logic        borrow0_q;
  logic        borrow2_q;
  logic        err_q;
  // Top two bits of an 18-bit subtraction; bit 2 is the no-borrow carry.
  assign hi_sum = {1'b0, hi_a} + 3'b011 + {2'b00, add_cout};
  assign bus.err = err_q;
`else
  logic [1:0]  hi_sum;
  // Top two bits of an 18-bit subtraction, carry out discarded.
  assign hi_sum = hi_a + 2'b11 + {1'b0, add_cout};
  assign bus.err = 1'b0;
`endif

  // Steer the shared adder according to the current compute phase.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    hi_a    = '0;
    case (state)
      SUB0: begin
        add_a   = z1_q[15:0];
        add_b   = ~z0_q;
        add_cin = 1'b1;
        hi_a    = z1_q[17:16];
      end
      SUB2: begin
        add_a   = d_q[15:0];
        add_b   = ~z2_q;
        add_cin = 1'b1;
        hi_a    = d_q[17:16];
      end
      ADDL: begin
        add_a   = {z2_q[7:0], z0_q[15:8]};
        add_b   = mid_q[15:0];
      end
      ADDH: begin
        add_a   = {8'h00, z2_q[15:8]};
        add_b   = {14'h0000, mid_q[17:16]};
        add_cin = c_q;
      end
      default: ;
    endcase
  end

  scb_cla16 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Control FSM with registered handshake outputs and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the working registers are discrete flops, not a memory, so they are reset with the rest.
      state       <= IDLE;
      z0_q        <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      d_q         <= '0;
      mid_q       <= '0;
      c_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
`ifdef KCOMB_CHECK_EN
      borrow0_q   <= 1'b0;
      borrow2_q   <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            z0_q       <= bus.z0;
            z1_q       <= bus.z1;
            z2_q       <= bus.z2;
            in_ready_q <= 1'b0;
            state      <= SUB0;
`ifdef KCOMB_CHECK_EN
            err_q      <= 1'b0;
`endif
          end
        end
        SUB0: begin
          d_q   <= {hi_sum[1:0], add_sum};
          state <= SUB2;
`ifdef KCOMB_CHECK_EN
          borrow0_q <= ~hi_sum[2];
`endif
        end
        SUB2: begin
          mid_q <= {hi_sum[1:0], add_sum};
          state <= ADDL;
`ifdef KCOMB_CHECK_EN
          borrow2_q <= ~hi_sum[2];
`endif
        end
        ADDL: begin
          prod_q[23:0] <= {add_sum, z0_q[7:0]};
          c_q          <= add_cout;
          state        <= ADDH;
        end
        ADDH: begin
          prod_q[31:24] <= add_sum[7:0];
          out_valid_q   <= 1'b1;
          state         <= DONE;
`ifdef KCOMB_CHECK_EN
          err_q <= borrow0_q | borrow2_q | mid_q[17];
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
endmodule

// File: tb/tb_karatsuba_combine16.sv
// Directed bench for karatsuba_combine16: nominal/max/zero/carry products,
// latency, backpressure, reset mid-operation and the KCOMB_CHECK_EN flag.
module tb_karatsuba_combine16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef KCOMB_CHECK_EN
  localparam logic EXP_CHK_ERR = 1'b1;
`else
  localparam logic EXP_CHK_ERR = 1'b0;
`endif

  karatsuba_combine16_if bus ();

  karatsuba_combine16 #(.HALF(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands after an edge, count edges until out_valid rises.
  // Edge 1 is the accept edge, so DONE shows up after edge 5.
  task automatic start_txn(input string tag, input logic [15:0] a0, input logic [17:0] a1,
                           input logic [15:0] a2, input logic [31:0] exp_prod,
                           input logic exp_err, input bit chk_prod);
    int k;
    check({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.z0 = a0;
    bus.z1 = a1;
    bus.z2 = a2;
    bus.in_valid = 1'b1;
    k = 0;
    do begin
      step();
      k++;
      if (k == 1) begin
        bus.in_valid = 1'b0;
        bus.z0 = 16'hA5A5;
        bus.z1 = 18'h25A5A;
        bus.z2 = 16'h5A5A;
        check({tag, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        check({tag, "/err_cleared"}, 32'(bus.err), 32'd0);
      end
    end while (!bus.out_valid && k < 20);
    check({tag, "/latency"}, k, 32'd5);
    check({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
    if (chk_prod) check({tag, "/prod"}, bus.prod, exp_prod);
    check({tag, "/err"}, 32'(bus.err), 32'(exp_err));
    check({tag, "/in_ready_done"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_txn(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "/out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.z0 = '0;
    bus.z1 = '0;
    bus.z2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready", 32'(bus.in_ready), 32'd1);
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/prod", bus.prod, 32'd0);
    check("rst/err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // a=0x1234, b=0x5678
    start_txn("nominal", 16'h1860, 18'h03854, 16'h060C, 32'h06260060, 1'b0, 1'b1);
    release_txn("nominal");

    // a=b=0xFFFF, mid=0x1FC02
    start_txn("max", 16'hFE01, 18'h3F804, 16'hFE01, 32'hFFFE0001, 1'b0, 1'b1);
    release_txn("max");

    start_txn("zero", 16'h0000, 18'h00000, 16'h0000, 32'h00000000, 1'b0, 1'b1);
    release_txn("zero");

    // a=0x0001, b=0x0100
    start_txn("mid_one", 16'h0000, 18'h00001, 16'h0000, 32'h00000100, 1'b0, 1'b1);
    release_txn("mid_one");

    // a=0x00FF, b=0xFF00
    start_txn("mid_only", 16'h0000, 18'h0FE01, 16'h0000, 32'h00FE0100, 1'b0, 1'b1);
    release_txn("mid_only");

    // Backpressure: a=b=0xFF80 (ADDL carries into the top byte), 0xFF80^2=0xFF004000
    start_txn("bp", 16'h4000, 18'h23D01, 16'hFE01, 32'hFF004000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.z0 = 16'h1111;
      bus.z1 = 18'h02222;
      bus.z2 = 16'h3333;
      step();
      check("bp/out_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp/prod_hold", bus.prod, 32'hFF004000);
      check("bp/in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    release_txn("bp");
    step();
    step();
    check("bp/no_ghost_valid", 32'(bus.out_valid), 32'd0);
    check("bp/no_ghost_ready", 32'(bus.in_ready), 32'd1);
    check("bp/prod_kept", bus.prod, 32'hFF004000);

    // Reset while in SUB2
    bus.z0 = 16'hFE01;
    bus.z1 = 18'h3F804;
    bus.z2 = 16'hFE01;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid/out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid/prod", bus.prod, 32'd0);
    check("rstmid/in_ready", 32'(bus.in_ready), 32'd1);
    check("rstmid/err", 32'(bus.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start_txn("post_rst", 16'h1860, 18'h03854, 16'h060C, 32'h06260060, 1'b0, 1'b1);
    release_txn("post_rst");

    // z1 < z0: flagged only when the check logic is built in
    start_txn("chk_bad", 16'h0010, 18'h00008, 16'h0000, 32'h0, EXP_CHK_ERR, 1'b0);
    release_txn("chk_bad");
    start_txn("chk_clear", 16'hFE01, 18'h3F804, 16'hFE01, 32'hFFFE0001, 1'b0, 1'b1);
    release_txn("chk_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
